mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage responder for the control decoder's M bundle {MemRead[1:0], MemWrite[1:0]}; encodings are 01 = word, 10 = byte.
- Executes the lw/lb/sw/sb command against a byte-wide data memory with a ready handshake.
- Stalls the pipeline until the access completes.
- Returns load data (word, or sign-extended byte) to the MEM/WB path.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ready on one beat before abort
ADDR_W, 32, address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
M  input  4  {MemRead[1:0], MemWrite[1:0]}; 00 = none, 01 = word, 10 = byte, 11 = illegal
addr  input  ADDR_W  ALU result, effective address
wdata  input  32  store data (rt)
stall  output  1  freeze PC/IF/ID/EX/MEM registers
done  output  1  one-cycle pulse, access finished, rdata valid for loads
err  output  1  one-cycle pulse together with done, command rejected or timed out
rdata  output  32  load result
mem_addr  output  ADDR_W  byte address to memory
mem_wdata  output  8  byte to write
mem_re  output  1  read request
mem_we  output  1  write request
mem_rdata  input  8  read byte, valid when mem_ready
mem_ready  input  1  beat completes on this edge when mem_re|mem_we

Behaviour:
- Reset (sync, rst=1 at edge):
  - State goes to IDLE; beat and timeout counters clear.
  - rdata=0.
  - stall, done, err, mem_re, mem_we are all 0; mem_addr=0; mem_wdata=0.
  - Reset overrides everything, including an in-flight access: request drops at that edge, no done pulse, partial write is not rolled back.
- FSM states IDLE, ACCESS, FIN.
- IDLE:
  - M==0 -> stay, stall=0.
  - M!=0 -> stall=1 combinationally in the same cycle.
  - At the edge, latch op, size, addr, wdata.
  - Next state is ACCESS if the command is legal, else FIN with err set.
- Illegal command, any of:
  - MemRead==11 or MemWrite==11.
  - MemRead and MemWrite both nonzero.
  - Word access with addr[1:0]!=0.
  - Illegal commands make no memory request.
- ACCESS:
  - stall=1; mem_re (load) or mem_we (store) held high with stable mem_addr/mem_wdata until mem_ready.
  - Word: 4 beats, big-endian, mem_addr={addr[ADDR_W-1:2], beat[1:0]}.
    - Beat 0 carries bits 31:24 … beat 3 carries bits 7:0, for both rdata assembly and mem_wdata.
  - Byte: 1 beat, mem_addr=addr, mem_wdata=wdata[7:0].
  - On mem_ready:
    - Capture mem_rdata into the byte lane; increment beat.
    - On the last beat, go to FIN; the request deasserts the same edge.
    - Back-to-back beats are allowed: the request stays high across beats when mem_ready is high every cycle.
  - Timeout counter counts cycles in the current beat without mem_ready and resets each beat.
    - Reaching TIMEOUT aborts: go to FIN with err=1, rdata unchanged, request deasserted.
- FIN:
  - stall=0, done=1 for exactly one cycle; err=1 if rejected or timed out.
  - Load success: rdata = assembled word, or {{24{b[7]}}, b} for lb, valid from this cycle.
  - rdata holds until the next successful load.
  - Next state is always IDLE, regardless of M (the pipeline advances at this edge).
- Latency with mem_ready tied high:
  - Byte: 3 cycles (stall high 2 cycles).
  - Word: 6 cycles (stall high 5 cycles).
  - Illegal: 2 cycles (stall high 1 cycle).
- Upstream contract: M/addr/wdata stay stable while stall=1. Values are latched at acceptance; later changes are ignored.
- mem_ready outside ACCESS is ignored.

Test Plan:
- lw, addr=0x100, memory bytes 0x100..0x103 = 12 34 56 78, mem_ready=1 -> stall high cycles 0–4, mem_addr 0x100..0x103, done at cycle 5, rdata=0x12345678, err=0.
- lb, addr=0x203, byte 0x9C -> one beat at 0x203, rdata=0xFFFFFF9C; then lb of byte 0x05 -> rdata=0x00000005.
- sw, addr=0x40, wdata=0xDEADBEEF, mem_ready low 2 cycles on beat 1 -> writes DE,AD,BE,EF to 0x40..0x43, mem_we/mem_addr/mem_wdata held stable during the wait, done one cycle after beat 3, stall high 7 cycles.
- Illegal commands -> no mem_re/mem_we ever, done=err=1 on cycle 1, rdata unchanged:
  - lw with addr=0x102.
  - M=4'b0101.
  - M=4'b1100.
- lw with mem_ready stuck 0, TIMEOUT=16 -> abort after 16 wait cycles, done=err=1, stall released, rdata unchanged.
- rst asserted mid-word-store after beat 1 -> next cycle mem_we=0, stall=0, no done, state IDLE; next sb is accepted normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer for a byte-wide data memory.
// Accepts the {MemRead, MemWrite} bundle, splits word accesses into four
// big-endian byte beats, stalls the pipeline while busy and returns load data.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   beat;
  logic [CW-1:0] wait_cnt;
  logic         is_word;
  logic [23:0]  wdata_q;  // remaining store bytes, next one in [23:16]
  logic [23:0]  rbuf;     // load bytes collected so far, newest in [7:0]

  logic [1:0] rd, wr;
  logic       cmd_word;
  logic       illegal;
  logic       last_beat;

  assign rd = M[3:2];
  assign wr = M[1:0];

  // Decode the incoming command and decide whether it can be executed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cmd_word = 1'b0;
    illegal  = 1'b0;
    cmd_word = ((rd | wr) == 2'b01);
    if ((rd == 2'b11) || (wr == 2'b11))  illegal = 1'b1;
    if ((rd != 2'b00) && (wr != 2'b00))  illegal = 1'b1;
    if (cmd_word && (addr[1:0] != 2'b00)) illegal = 1'b1;
  end

  assign last_beat = !is_word || (beat == 2'd3);

  // The pipeline is frozen from the cycle a command appears until FIN.
  assign stall = (state == ACCESS) || ((state == IDLE) && (M != 4'b0000));

  // Main sequencer: accept, run the byte beats, then pulse done for a cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (rst) begin
      state     <= IDLE;
      beat      <= 2'd0;
      wait_cnt  <= '0;
      is_word   <= 1'b0;
      wdata_q   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (M != 4'b0000) begin
            beat     <= 2'd0;
            wait_cnt <= '0;
            is_word  <= cmd_word;
            if (illegal) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state  <= ACCESS;
              mem_re <= (rd != 2'b00);
              mem_we <= (wr != 2'b00);
              if (cmd_word) begin
                mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdata[31:24];
                wdata_q   <= wdata[23:0];
              end else begin
                mem_addr  <= addr;
                mem_wdata <= wdata[7:0];
                wdata_q   <= '0;
              end
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (last_beat) begin
              state  <= FIN;
              done   <= 1'b1;
              mem_re <= 1'b0;
              mem_we <= 1'b0;
              if (mem_re) begin
                rdata <= is_word ? {rbuf, mem_rdata}
                                 : {{24{mem_rdata[7]}}, mem_rdata};
              end
            end else begin
              beat      <= beat + 2'd1;
              mem_addr  <= {mem_addr[ADDR_W-1:2], beat + 2'd1};
              mem_wdata <= wdata_q[23:16];
              wdata_q   <= {wdata_q[15:0], 8'h00};
            end
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Memory never answered this beat: abort, leave rdata untouched.
            state  <= FIN;
            done   <= 1'b1;
            err    <= 1'b1;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Collect load bytes MSB-first; the final byte goes straight into rdata.
  always_ff @(posedge clk) begin
    // NOTE: rbuf is deliberately not reset; every byte is shifted in before
    // rdata ever reads it.
    if ((state == ACCESS) && mem_ready && mem_re) begin
      rbuf <= {rbuf[15:0], mem_rdata};
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table of load/store/illegal/timeout commands
// against a byte-memory model, plus a hand-written reset-during-store sequence.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  logic [7:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .M         (M),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Byte memory model: combinational read, write on a completed store beat.
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_we && mem_ready) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pat;    // mem_ready value per cycle index (cycle 0 = accept)
    int          lat;    // cycle index where done is seen
    int          stl;    // cycles with stall high
    logic        err;
    logic [31:0] rdata;
    logic        req;    // any mem_re/mem_we expected
    int          beats;  // completed beats expected
  } vec_t;

  // Issue one command and compare everything observable against v.
  task automatic run_vec(input vec_t v);
    int c, stl, stab_err;
    logic req, prev_wait, prev_re, prev_we, word;
    logic [31:0] prev_addr, exp_a;
    logic [7:0]  prev_wd, exp_w;
    logic [31:0] q_addr[$];
    logic [7:0]  q_wd[$];
    c = 0; stl = 0; stab_err = 0; req = 1'b0; prev_wait = 1'b0;
    prev_re = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wd = '0;
    word = ((v.m[3:2] | v.m[1:0]) == 2'b01);
    @(negedge clk);
    M = v.m; addr = v.addr; wdata = v.wdata;
    while (1) begin
      mem_ready = (c < 32) ? v.pat[c] : 1'b1;
      #1;
      if (stall) stl++;
      if (done) break;
      if (prev_wait && ((mem_addr !== prev_addr) || (mem_wdata !== prev_wd) ||
                        (mem_re !== prev_re) || (mem_we !== prev_we)))
        stab_err++;
      if (mem_re || mem_we) req = 1'b1;
      if ((mem_re || mem_we) && mem_ready) begin
        q_addr.push_back(mem_addr);
        q_wd.push_back(mem_wdata);
      end
      prev_wait = (mem_re || mem_we) && !mem_ready;
      prev_addr = mem_addr; prev_wd = mem_wdata; prev_re = mem_re; prev_we = mem_we;
      if (c >= 60) break;
      @(negedge clk);
      c++;
    end
    check({v.name, " done_cycle"}, c, v.lat);
    check({v.name, " stall_cycles"}, stl, v.stl);
    check({v.name, " err"}, {31'b0, err}, {31'b0, v.err});
    check({v.name, " rdata"}, rdata, v.rdata);
    check({v.name, " req_seen"}, {31'b0, req}, {31'b0, v.req});
    check({v.name, " beats"}, q_addr.size(), v.beats);
    check({v.name, " held_stable"}, stab_err, 0);
    for (int i = 0; i < q_addr.size() && i < v.beats; i++) begin
      exp_a = word ? {v.addr[31:2], 2'(i)} : v.addr;
      check({v.name, " beat_addr"}, q_addr[i], exp_a);
      if (v.m[1:0] != 2'b00) begin
        exp_w = word ? v.wdata[8*(3-i) +: 8] : v.wdata[7:0];
        check({v.name, " beat_wdata"}, {24'b0, q_wd[i]}, {24'b0, exp_w});
      end
    end
    M = 4'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    check({v.name, " done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"lw_100",   4'b0100, 32'h100, 32'h0,        32'hFFFF_FFFF, 5,  5,  1'b0, 32'h12345678, 1'b1, 4};
    vecs[1] = '{"lb_neg",   4'b1000, 32'h203, 32'h0,        32'hFFFF_FFFF, 2,  2,  1'b0, 32'hFFFFFF9C, 1'b1, 1};
    vecs[2] = '{"lb_pos",   4'b1000, 32'h204, 32'h0,        32'hFFFF_FFFF, 2,  2,  1'b0, 32'h00000005, 1'b1, 1};
    vecs[3] = '{"sw_wait",  4'b0001, 32'h040, 32'hDEADBEEF, 32'hFFFF_FFF3, 7,  7,  1'b0, 32'h00000005, 1'b1, 4};
    vecs[4] = '{"lw_unal",  4'b0100, 32'h102, 32'h0,        32'hFFFF_FFFF, 1,  1,  1'b1, 32'h00000005, 1'b0, 0};
    vecs[5] = '{"rd_wr",    4'b0101, 32'h100, 32'h0,        32'hFFFF_FFFF, 1,  1,  1'b1, 32'h00000005, 1'b0, 0};
    vecs[6] = '{"rd_11",    4'b1100, 32'h100, 32'h0,        32'hFFFF_FFFF, 1,  1,  1'b1, 32'h00000005, 1'b0, 0};
    vecs[7] = '{"sb_44",    4'b0010, 32'h044, 32'h000000A5, 32'hFFFF_FFFF, 2,  2,  1'b0, 32'h00000005, 1'b1, 1};
    vecs[8] = '{"lw_tmo",   4'b0100, 32'h100, 32'h0,        32'h0000_0000, 17, 17, 1'b1, 32'h00000005, 1'b1, 0};
    vecs[9] = '{"lw_again", 4'b0100, 32'h100, 32'h0,        32'hFFFF_FFFF, 5,  5,  1'b0, 32'h12345678, 1'b1, 4};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h12; mem[10'h101] = 8'h34; mem[10'h102] = 8'h56; mem[10'h103] = 8'h78;
    mem[10'h203] = 8'h9C; mem[10'h204] = 8'h05;

    rst = 1'b1; M = 4'b0; addr = '0; wdata = '0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst done_err", {30'b0, done, err}, 32'd0);
    check("rst req", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", {24'b0, mem_wdata}, 32'd0);
    rst = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    check("mem 40", {24'b0, mem[10'h040]}, 32'hDE);
    check("mem 41", {24'b0, mem[10'h041]}, 32'hAD);
    check("mem 42", {24'b0, mem[10'h042]}, 32'hBE);
    check("mem 43", {24'b0, mem[10'h043]}, 32'hEF);
    check("mem 44", {24'b0, mem[10'h044]}, 32'hA5);

    // Reset in the middle of a word store, after beats 0 and 1 complete.
    @(negedge clk);
    M = 4'b0001; addr = 32'h48; wdata = 32'h11223344; mem_ready = 1'b1;
    @(negedge clk);                 // beat 0
    @(negedge clk);                 // beat 1
    @(negedge clk);                 // beat 2 requested
    #1;
    check("rst_mid beat2 req", {31'b0, mem_we}, 32'd1);
    mem_ready = 1'b0; rst = 1'b1; M = 4'b0;
    @(negedge clk); #1;
    check("rst_mid mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mid stall", {31'b0, stall}, 32'd0);
    check("rst_mid done", {31'b0, done}, 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_mid no_done", {31'b0, done}, 32'd0);
    check("rst_mid mem 48", {24'b0, mem[10'h048]}, 32'h11);
    check("rst_mid mem 49", {24'b0, mem[10'h049]}, 32'h22);
    check("rst_mid mem 4a", {24'b0, mem[10'h04A]}, 32'h00);
    run_vec('{"sb_after_rst", 4'b0010, 32'h04C, 32'h00000077, 32'hFFFF_FFFF, 2, 2, 1'b0, 32'h00000000, 1'b1, 1});
    check("mem 4c", {24'b0, mem[10'h04C]}, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
